// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, funct3
// access-size codes, byte-enable width and the access legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  // Misaligned halfword/word, reserved funct3, or unsigned-size store.
  function automatic logic lsu_access_fault(input logic [2:0] f3,
                                            input logic [1:0] a,
                                            input logic       we);
    logic flt;
    case (f3)
      F3_B:    flt = 1'b0;
      F3_BU:   flt = we;
      F3_H:    flt = a[0];
      F3_HU:   flt = we | a[0];
      F3_W:    flt = (a != 2'b00);
      default: flt = 1'b1;
    endcase
    return flt;
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Load lane extraction: shifts the addressed byte/halfword down to bit 0 and
// sign- or zero-extends it according to funct3.
module lsu_load_format
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_offset,
  input  logic [2:0]            i_funct3,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_lane;

  assign w_lane = i_rdata >> {i_offset, 3'b000};

  // Extend the selected lane to a full word
  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
      F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]};
      F3_H:    o_data = {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
      F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]};
      F3_W:    o_data = w_lane;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: drives one ready-handshake bus access per memory
// instruction and stalls the core until the access completes.
// Optional build macro LSU_TIMEOUT_EN: aborts a request after
// TIMEOUT_CYCLES REQ cycles without Bus_Ready_i and pulses Fault_o.
//
// state | meaning
// IDLE  | no access in flight; start on a legal req, flag illegal ones
// REQ   | bus request held, waiting for Bus_Ready_i (or timeout)
// DONE  | access finished; core commits this cycle, req ignored
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Mem_Read_i,
  input  logic                  Mem_Write_i,
  input  logic [2:0]            Funct3_i,
  input  logic [ADDR_WIDTH-1:0] Address_i,
  input  logic [DATA_WIDTH-1:0] Store_Data_i,
  output logic [DATA_WIDTH-1:0] Load_Data_o,
  output logic                  Stall_o,
  output logic                  Fault_o,
  output logic                  Bus_Req_o,
  output logic                  Bus_We_o,
  output logic [ADDR_WIDTH-1:0] Bus_Addr_o,
  output logic [BE_W-1:0]       Bus_Be_o,
  output logic [DATA_WIDTH-1:0] Bus_Wdata_o,
  input  logic [DATA_WIDTH-1:0] Bus_Rdata_i,
  input  logic                  Bus_Ready_i
);

  lsu_state_e            r_state;
  logic                  r_bus_req;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BE_W-1:0]       r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic [2:0]            r_f3;
  logic [1:0]            r_off;

  logic                  w_req;
  logic                  w_fault;
  logic                  w_start;
  logic                  w_fault_now;
  logic                  w_stall;
  logic                  w_to_expire;
  logic                  w_to_fault;
  logic [BE_W-1:0]       w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_fmt;

  // A set Mem_Write_i makes the access a store even if Mem_Read_i is also set
  assign w_req       = Mem_Read_i | Mem_Write_i;
  assign w_fault     = lsu_access_fault(Funct3_i, Address_i[1:0], Mem_Write_i);
  assign w_start     = (r_state == ST_IDLE) && w_req && !w_fault;
  assign w_fault_now = (r_state == ST_IDLE) && w_req && w_fault;

  // Store lane steering: byte enables and replicated write data
  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    case (Funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << Address_i[1:0];
        w_wdata = {4{Store_Data_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {Address_i[1], 1'b0};
        w_wdata = {2{Store_Data_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = Store_Data_i;
      end
    endcase
  end

  lsu_load_format #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_format (
    .i_rdata  (Bus_Rdata_i),
    .i_offset (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_fmt)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int TO_CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W    = (TO_CLOG > 8) ? TO_CLOG : 8;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_to_fault;

  // Down-count REQ cycles; terminal count without ready aborts the access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt   <= '0;
      r_to_fault <= 1'b0;
    end else begin
      r_to_fault <= w_to_expire;
      if (w_start)
        r_to_cnt <= TO_LOAD;
      else if (r_state == ST_REQ && r_to_cnt != '0)
        r_to_cnt <= r_to_cnt - 1'b1;
    end
  end

  assign w_to_expire = (r_state == ST_REQ) && !Bus_Ready_i && (r_to_cnt == '0);
  assign w_to_fault  = r_to_fault;
`else
  assign w_to_expire = 1'b0;
  assign w_to_fault  = 1'b0;
`endif

  // Access sequencer with registered bus outputs and load result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_bus_req   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
      r_f3        <= '0;
      r_off       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_bus_req <= 1'b1;
            r_we      <= Mem_Write_i;
            r_addr    <= {Address_i[ADDR_WIDTH-1:2], 2'b00};
            r_be      <= w_be;
            r_wdata   <= Mem_Write_i ? w_wdata : '0;
            r_f3      <= Funct3_i;
            r_off     <= Address_i[1:0];
            r_state   <= ST_REQ;
          end else if (w_fault_now && !Mem_Write_i) begin
            r_load_data <= '0;
          end
        end
        ST_REQ: begin
          if (Bus_Ready_i) begin
            r_bus_req <= 1'b0;
            if (!r_we)
              r_load_data <= w_fmt;
            r_state <= ST_DONE;
          end else if (w_to_expire) begin
            r_bus_req <= 1'b0;
            if (!r_we)
              r_load_data <= '0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall the core for a legal pending access and while the bus is busy
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: w_stall = w_req & ~w_fault;
      ST_REQ:  w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  assign Stall_o     = w_stall;
  assign Fault_o     = w_fault_now | w_to_fault;
  assign Bus_Req_o   = r_bus_req;
  assign Bus_We_o    = r_we;
  assign Bus_Addr_o  = r_addr;
  assign Bus_Be_o    = r_be;
  assign Bus_Wdata_o = r_wdata;
  assign Load_Data_o = r_load_data;

endmodule
